// File: rtl/tmds_encoder_8b10b.sv
// TMDS channel encoder (DVI 1.0 8b/10b transition-minimising, DC-balancing code).
// One 10-bit character is produced every pixel clock. There is no backpressure:
// each clock carries one character and o_de marks whether it is a data
// character (1) or a control token (0). A character reflects the inputs
// presented three clocks earlier: each of the three stages below holds one
// register level.
//   stage 1: capture inputs, count ones in the pixel byte
//   stage 2: pick XOR/XNOR, build q_m[8:0], count ones in q_m[7:0]
//   stage 3: choose inversion, emit the character, update running disparity
module tmds_encoder_8b10b #(
    parameter bit REVERSE_BITS = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_de,
    input  logic [7:0]        i_data,
    input  logic              i_c0,
    input  logic              i_c1,
    output logic [9:0]        o_tmds,
    output logic              o_de,
    output logic signed [4:0] o_disparity
);

    // Control tokens indexed by {C1, C0}; bit 0 is the first bit on the wire.
    localparam logic [9:0] TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] TOKEN_11 = 10'b1010101011;

    // Number of ones in a byte, 0..8.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Transition-minimised word: running XOR or XNOR chain, bit 8 flags XOR.
    function automatic logic [8:0] minimise(input logic [7:0] d, input logic use_xnor);
        logic [8:0] q;
        q    = 9'd0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    // Token lookup for the control period.
    function automatic logic [9:0] control_token(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b00:   t = TOKEN_00;
            2'b01:   t = TOKEN_01;
            2'b10:   t = TOKEN_10;
            default: t = TOKEN_11;
        endcase
        return t;
    endfunction

    // ------------------------------------------------------------------
    // Stage 1 signals
    // ------------------------------------------------------------------
    logic       s1_de;
    logic [7:0] s1_data;
    logic [1:0] s1_c;
    logic [3:0] s1_n1d;

    // ------------------------------------------------------------------
    // Stage 2 signals
    // ------------------------------------------------------------------
    logic       s2_use_xnor;
    logic [8:0] s2_qm_next;
    logic [3:0] s2_n1q_next;
    logic       s2_de;
    logic [1:0] s2_c;
    logic [8:0] s2_qm;
    logic [3:0] s2_n1q;
    logic [3:0] s2_n0q;

    // ------------------------------------------------------------------
    // Stage 3 signals
    // ------------------------------------------------------------------
    logic signed [4:0] n1q_s;
    logic signed [4:0] n0q_s;
    logic signed [4:0] diff_1m0;
    logic signed [4:0] diff_0m1;
    logic              cnt_is_zero;
    logic              ones_balanced;
    logic              invert_needed;
    logic [9:0]        tmds_next;
    logic signed [4:0] cnt_next;
    logic [9:0]        tmds_r;
    logic              de_r;
    logic signed [4:0] cnt;

    // Stage 1: capture the inputs and count ones in the pixel byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_de   <= 1'b0;
            s1_data <= 8'd0;
            s1_c    <= 2'b00;
            s1_n1d  <= 4'd0;
        end else begin
            s1_de   <= i_de;
            s1_data <= i_data;
            s1_c    <= {i_c1, i_c0};
            s1_n1d  <= popcount8(i_data);
        end
    end

    // Stage 2 comb: XNOR when the byte is one-heavy (ties broken on bit 0).
    always_comb begin
        s2_use_xnor = (s1_n1d > 4'd4) || ((s1_n1d == 4'd4) && !s1_data[0]);
        s2_qm_next  = minimise(s1_data, s2_use_xnor);
        s2_n1q_next = popcount8(s2_qm_next[7:0]);
    end

    // Stage 2: register q_m with its ones/zeros counts; control rides along.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_de  <= 1'b0;
            s2_c   <= 2'b00;
            s2_qm  <= 9'd0;
            s2_n1q <= 4'd0;
            s2_n0q <= 4'd0;
        end else begin
            s2_de  <= s1_de;
            s2_c   <= s1_c;
            s2_qm  <= s2_qm_next;
            s2_n1q <= s2_n1q_next;
            s2_n0q <= 4'd8 - s2_n1q_next;
        end
    end

    // Stage 3 comb: sign-extended disparity terms and branch conditions.
    always_comb begin
        n1q_s         = signed'({1'b0, s2_n1q});
        n0q_s         = signed'({1'b0, s2_n0q});
        diff_1m0      = n1q_s - n0q_s;
        diff_0m1      = n0q_s - n1q_s;
        cnt_is_zero   = (cnt == 5'sd0);
        ones_balanced = (s2_n1q == s2_n0q);
        invert_needed = ((cnt > 5'sd0) && (s2_n1q > s2_n0q)) ||
                        ((cnt < 5'sd0) && (s2_n0q > s2_n1q));
    end

    // Stage 3 comb: pick the character and the next running disparity.
    always_comb begin
        tmds_next = TOKEN_00;
        cnt_next  = 5'sd0;
        if (!s2_de) begin
            // Control period: token out, disparity restarts from zero.
            tmds_next = control_token(s2_c);
            cnt_next  = 5'sd0;
        end else if (cnt_is_zero || ones_balanced) begin
            // No bias to correct: bit 9 tells the decoder whether bits 7:0 are inverted.
            tmds_next = {~s2_qm[8], s2_qm[8], s2_qm[8] ? s2_qm[7:0] : ~s2_qm[7:0]};
            cnt_next  = s2_qm[8] ? (cnt + diff_1m0) : (cnt + diff_0m1);
        end else if (invert_needed) begin
            // Character would deepen the current bias: send it inverted.
            tmds_next = {1'b1, s2_qm[8], ~s2_qm[7:0]};
            cnt_next  = cnt + (s2_qm[8] ? 5'sd2 : 5'sd0) + diff_0m1;
        end else begin
            // Character already pulls the bias back toward zero: send as is.
            tmds_next = {1'b0, s2_qm[8], s2_qm[7:0]};
            cnt_next  = cnt - (s2_qm[8] ? 5'sd0 : 5'sd2) + diff_1m0;
        end
    end

    // Stage 3: output character, aligned data enable and running disparity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmds_r <= TOKEN_00;
            de_r   <= 1'b0;
            cnt    <= 5'sd0;
        end else begin
            tmds_r <= tmds_next;
            de_r   <= s2_de;
            cnt    <= cnt_next;
        end
    end

    // Optional bit-order reversal for serializers that shift out MSB first.
    generate
        if (REVERSE_BITS) begin : g_reverse
            // Mirror the character; the encoding itself is untouched.
            always_comb begin
                o_tmds = 10'd0;
                for (int i = 0; i < 10; i++) begin
                    o_tmds[i] = tmds_r[9-i];
                end
            end
        end else begin : g_forward
            assign o_tmds = tmds_r;
        end
    endgenerate

    assign o_de        = de_r;
    assign o_disparity = cnt;

endmodule

// File: tb/tb_tmds_encoder_8b10b.sv
// Self-checking bench for tmds_encoder_8b10b: hand-computed vector table,
// a golden integer model of the DVI encoder for a long random run, and
// hand-written reset sequences. A forward and a bit-reversed instance run
// side by side on the same stimulus.
module tb_tmds_encoder_8b10b;

    logic              clk;
    logic              rst_n;
    logic              i_de;
    logic [7:0]        i_data;
    logic              i_c0;
    logic              i_c1;
    logic [9:0]        o_tmds;
    logic              o_de;
    logic signed [4:0] o_disparity;
    logic [9:0]        rev_tmds;
    logic              rev_de;
    logic signed [4:0] rev_disparity;

    int n_vec;
    int n_fail;
    int model_cnt;

    // Expected entry: {id[15:0], chk, de, disp[4:0], tmds[9:0]}
    logic [32:0] exp_q[$];

    typedef struct {
        logic              de;
        logic [7:0]        data;
        logic [1:0]        c;
        logic [9:0]        tmds;
        logic signed [4:0] disp;
    } vec_t;

    vec_t tbl[24];

    tmds_encoder_8b10b #(.REVERSE_BITS(1'b0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_de        (i_de),
        .i_data      (i_data),
        .i_c0        (i_c0),
        .i_c1        (i_c1),
        .o_tmds      (o_tmds),
        .o_de        (o_de),
        .o_disparity (o_disparity)
    );

    tmds_encoder_8b10b #(.REVERSE_BITS(1'b1)) dut_rev (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_de        (i_de),
        .i_data      (i_data),
        .i_c0        (i_c0),
        .i_c1        (i_c1),
        .o_tmds      (rev_tmds),
        .o_de        (rev_de),
        .o_disparity (rev_disparity)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time %0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [9:0] rev10(input logic [9:0] v);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = v[9-i];
        return r;
    endfunction

    // Golden DVI 1.0 encoder model; keeps its running disparity in model_cnt.
    function automatic logic [9:0] model_step(input logic de, input logic [7:0] d, input logic [1:0] c);
        logic [8:0] qm;
        logic [9:0] q_out;
        logic       use_xnor;
        int         n1d;
        int         n1;
        int         n0;
        if (!de) begin
            model_cnt = 0;
            case (c)
                2'b00:   q_out = 10'h354;
                2'b01:   q_out = 10'h0AB;
                2'b10:   q_out = 10'h154;
                default: q_out = 10'h2AB;
            endcase
            return q_out;
        end
        n1d = $countones(d);
        use_xnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            if (use_xnor) qm[i] = ~(qm[i-1] ^ d[i]);
            else          qm[i] = qm[i-1] ^ d[i];
        end
        qm[8] = !use_xnor;
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        if (model_cnt == 0 || n1 == n0) begin
            q_out[9]   = ~qm[8];
            q_out[8]   = qm[8];
            q_out[7:0] = qm[8] ? qm[7:0] : ~qm[7:0];
            if (qm[8]) model_cnt = model_cnt + (n1 - n0);
            else       model_cnt = model_cnt + (n0 - n1);
        end else if ((model_cnt > 0 && n1 > n0) || (model_cnt < 0 && n0 > n1)) begin
            q_out = {1'b1, qm[8], ~qm[7:0]};
            model_cnt = model_cnt + (qm[8] ? 2 : 0) + (n0 - n1);
        end else begin
            q_out = {1'b0, qm[8], qm[7:0]};
            model_cnt = model_cnt - (qm[8] ? 0 : 2) + (n1 - n0);
        end
        return q_out;
    endfunction

    // Compare both instances against one expected character.
    task automatic check(input string name, input logic [9:0] et, input logic ede, input logic [4:0] ed);
        logic [9:0] er;
        er = rev10(et);
        n_vec++;
        if (o_tmds !== et || o_de !== ede || o_disparity !== ed ||
            rev_tmds !== er || rev_de !== ede || rev_disparity !== ed) begin
            n_fail++;
            $display("FAIL %s: got tmds=%h de=%b disp=%0d rev=%h rev_de=%b rev_disp=%0d, want tmds=%h de=%b disp=%0d rev=%h",
                     name, o_tmds, o_de, o_disparity, rev_tmds, rev_de, rev_disparity,
                     et, ede, $signed(ed), er);
        end
    endtask

    // Drive one character's inputs, record its expectation, advance a clock
    // and score the character that is due at the output now.
    task automatic step(input logic de, input logic [7:0] d, input logic [1:0] c,
                        input logic [9:0] et, input logic [4:0] ed,
                        input logic chk, input logic [15:0] id);
        logic [32:0] e;
        i_de   = de;
        i_data = d;
        i_c1   = c[1];
        i_c0   = c[0];
        exp_q.push_back({id, chk, de, ed, et});
        @(negedge clk);
        if (exp_q.size() == 3) begin
            e = exp_q.pop_front();
            if (e[16]) check($sformatf("vec%0d", e[32:17]), e[9:0], e[15], e[14:10]);
        end
    endtask

    // Pipeline registers still hold reset values for two clocks after release.
    task automatic preload_reset;
        exp_q.delete();
        repeat (2) exp_q.push_back({16'hFFFF, 1'b1, 1'b0, 5'd0, 10'h354});
    endtask

    // Push out the last two characters of a sequence.
    task automatic flush;
        repeat (2) step(1'b0, 8'h00, 2'b00, 10'h354, 5'd0, 1'b0, 16'd0);
        exp_q.delete();
    endtask

    initial begin
        logic              de;
        logic [7:0]        d;
        logic [1:0]        c;
        logic [9:0]        et;

        n_vec     = 0;
        n_fail    = 0;
        model_cnt = 0;

        // {de, data, c, expected tmds, expected disparity}
        tbl[0]  = '{1'b0, 8'h00, 2'b00, 10'h354,  5'sd0};
        tbl[1]  = '{1'b0, 8'h00, 2'b01, 10'h0AB,  5'sd0};
        tbl[2]  = '{1'b0, 8'h00, 2'b10, 10'h154,  5'sd0};
        tbl[3]  = '{1'b0, 8'h00, 2'b11, 10'h2AB,  5'sd0};
        tbl[4]  = '{1'b1, 8'h00, 2'b11, 10'h100, -5'sd8};
        tbl[5]  = '{1'b1, 8'h00, 2'b11, 10'h3FF,  5'sd2};
        tbl[6]  = '{1'b1, 8'h00, 2'b00, 10'h100, -5'sd6};
        tbl[7]  = '{1'b1, 8'h00, 2'b00, 10'h3FF,  5'sd4};
        tbl[8]  = '{1'b1, 8'h55, 2'b00, 10'h133,  5'sd4};
        tbl[9]  = '{1'b1, 8'hAA, 2'b00, 10'h233,  5'sd4};
        tbl[10] = '{1'b0, 8'hFF, 2'b00, 10'h354,  5'sd0};
        tbl[11] = '{1'b1, 8'hFF, 2'b00, 10'h200, -5'sd8};
        tbl[12] = '{1'b1, 8'hFF, 2'b00, 10'h0FF, -5'sd2};
        tbl[13] = '{1'b1, 8'hFF, 2'b00, 10'h0FF,  5'sd4};
        tbl[14] = '{1'b1, 8'hFF, 2'b00, 10'h200, -5'sd4};
        tbl[15] = '{1'b0, 8'h00, 2'b00, 10'h354,  5'sd0};
        tbl[16] = '{1'b1, 8'h00, 2'b00, 10'h100, -5'sd8};
        tbl[17] = '{1'b0, 8'h00, 2'b01, 10'h0AB,  5'sd0};
        tbl[18] = '{1'b1, 8'h01, 2'b10, 10'h1FF,  5'sd8};
        tbl[19] = '{1'b1, 8'h55, 2'b00, 10'h133,  5'sd8};
        tbl[20] = '{1'b1, 8'h01, 2'b00, 10'h300,  5'sd2};
        tbl[21] = '{1'b1, 8'h0F, 2'b00, 10'h105, -5'sd2};
        tbl[22] = '{1'b1, 8'h0F, 2'b00, 10'h3FA,  5'sd4};
        tbl[23] = '{1'b0, 8'h00, 2'b11, 10'h2AB,  5'sd0};

        // Reset held with busy-looking inputs: outputs must stay at reset values.
        rst_n  = 1'b0;
        i_de   = 1'b1;
        i_data = 8'hA5;
        i_c0   = 1'b1;
        i_c1   = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_hold", 10'h354, 1'b0, 5'd0);

        // Release on a falling edge and start the table immediately.
        rst_n = 1'b1;
        preload_reset();
        for (int i = 0; i < 24; i++) begin
            step(tbl[i].de, tbl[i].data, tbl[i].c, tbl[i].tmds, tbl[i].disp, 1'b1, 16'(i));
        end

        // Long run against the golden model: alternating DE first, then mostly data.
        model_cnt = 0;
        for (int k = 0; k < 10000; k++) begin
            if (k < 300) de = k[0];
            else         de = ($urandom_range(0, 7) != 0);
            d  = 8'($urandom_range(0, 255));
            c  = 2'($urandom_range(0, 3));
            et = model_step(de, d, c);
            step(de, d, c, et, model_cnt[4:0], 1'b1, 16'(1000 + k));
        end

        // Fill the pipeline with data, then pull reset between clock edges.
        for (int k = 0; k < 4; k++) begin
            et = model_step(1'b1, 8'h00, 2'b00);
            step(1'b1, 8'h00, 2'b00, et, model_cnt[4:0], 1'b1, 16'(20000 + k));
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 10'h354, 1'b0, 5'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("reset_held_clocked", 10'h354, 1'b0, 5'd0);

        // Restart: disparity begins at zero again.
        rst_n = 1'b1;
        preload_reset();
        step(1'b1, 8'h00, 2'b00, 10'h100, -5'sd8, 1'b1, 16'd30000);
        step(1'b1, 8'h00, 2'b00, 10'h3FF,  5'sd2, 1'b1, 16'd30001);
        step(1'b0, 8'h00, 2'b10, 10'h154,  5'sd0, 1'b1, 16'd30002);
        step(1'b1, 8'hFF, 2'b00, 10'h200, -5'sd8, 1'b1, 16'd30003);
        flush();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
